// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

    // Fetch controller states: idle, request outstanding, request abandoned by flush.
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_e;

    // Program counter advance per accepted instruction.
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy output; storage is not reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;

    // Pointer and occupancy next-state; flush wins over same-cycle push/pop.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + {{PtrW{1'b0}}, push_i} - {{PtrW{1'b0}}, pop_i};
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written on push only.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues memory reads at pc_i and queues returned
// instructions with their fetch address for the decoder.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              in,
    input  logic [31:0]       pc_i,
    output logic [31:0]       increment_o,
    output logic              mem_req_o,
    output logic [31:0]       mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [31:0]       inst_pc_o,
    input  logic              inst_ready_i,
    input  logic              flush_i
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned EntW = 32 + DATA_W;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic            push;
    logic            pop;
    logic [CntW-1:0] count;
    logic [CntW-1:0] count_post;
    logic [EntW-1:0] head;

    assign pop        = inst_valid_o && inst_ready_i;
    // Occupancy after this cycle's push and pop; only meaningful when pushing.
    assign count_post = count + CntW'(1) - {{(CntW-1){1'b0}}, pop};

    // Next state, request, PC step and push decode.
    always_comb begin
        state_d     = state_q;
        push        = 1'b0;
        mem_req_o   = 1'b0;
        increment_o = '0;
        unique case (state_q)
            IDLE: begin
                if (count < DepthC && !flush_i) state_d = REQ;
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    // The PC advances even when a flush discards the data.
                    increment_o = PC_STEP;
                    if (flush_i) begin
                        state_d = IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = (count_post < DepthC) ? REQ : IDLE;
                    end
                end else if (flush_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!in) state_q <= IDLE;
        else     state_q <= state_d;
    end

    sync_fifo #(
        .WIDTH (EntW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_ni  (in),
        .push_i  (push),
        .wdata_i ({pc_i, mem_rdata_i}),
        .pop_i   (pop),
        .flush_i (flush_i),
        .rdata_o (head),
        .count_o (count)
    );

    assign mem_addr_o   = pc_i;
    assign inst_valid_o = (count != '0);
    assign inst_o       = head[DATA_W-1:0];
    assign inst_pc_o    = head[EntW-1 -: 32];

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus random traffic,
// checked by a queue-based reference model and a decoupled output monitor.
module tb_fetch_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              in = 1'b0;
    logic [31:0]       pc_i = '0;
    logic [31:0]       increment_o;
    logic              mem_req_o;
    logic [31:0]       mem_addr_o;
    logic              mem_ack_i = 1'b0;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [31:0]       inst_pc_o;
    logic              inst_ready_i = 1'b0;
    logic              flush_i = 1'b0;

    fetch_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .in           (in),
        .pc_i         (pc_i),
        .increment_o  (increment_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_ready_i (inst_ready_i),
        .flush_i      (flush_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: request outstanding / being discarded, occupancy, PC.
    bit          m_busy   = 1'b0;
    bit          m_drop   = 1'b0;
    int          m_count  = 0;
    int          m_pushes = 0;
    logic [31:0] m_pc     = '0;
    bit          chk_en   = 1'b0;
    logic [63:0] sb_q[$];

    logic [31:0] last_inc;
    int          hits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus, then the model absorbs that cycle's inputs.
    task automatic step(input logic r, input logic a, input logic [31:0] d,
                        input logic rdy, input logic f);
        int c0, inc;
        bit popv, pushv;
        in = r; mem_ack_i = a; mem_rdata_i = d; inst_ready_i = rdy; flush_i = f;
        pc_i = m_pc;
        @(negedge clk);
        last_inc = increment_o;
        @(posedge clk);
        #1;
        c0    = m_count;
        popv  = (c0 != 0) && rdy;
        pushv = 1'b0;
        inc   = (m_busy && !m_drop && a) ? 4 : 0;
        if (!r) begin
            m_busy = 0; m_drop = 0; m_count = 0; m_pc = '0;
            sb_q.delete();
            chk_en = 1'b1;
        end else begin
            m_pc = m_pc + inc;
            if (!m_busy) begin
                m_busy = (c0 < DEPTH) && !f;
            end else if (m_drop) begin
                if (a) begin m_busy = 0; m_drop = 0; end
            end else if (a) begin
                if (f) m_busy = 0;
                else   pushv = 1'b1;
            end else if (f) begin
                m_drop = 1;
            end
            m_count = c0 + int'(pushv) - int'(popv);
            if (pushv) begin
                sb_q.push_back({pc_i, d});
                m_pushes++;
                m_busy = (m_count < DEPTH);
            end
            if (f) begin
                m_count = 0;
                sb_q.delete();
            end
        end
    endtask

    // Monitor: per-cycle control outputs and head-of-queue pops vs the model.
    always @(negedge clk) begin
        logic [63:0] e;
        if (chk_en) begin
            chk("mem_req", {31'd0, mem_req_o}, {31'd0, m_busy});
            chk("increment", increment_o, (m_busy && !m_drop && mem_ack_i) ? 32'd4 : 32'd0);
            chk("mem_addr", mem_addr_o, pc_i);
            chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, m_count != 0});
            if (inst_valid_o && inst_ready_i) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pop_empty: got unexpected pop of %h expected none", inst_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("inst", inst_o, e[31:0]);
                    chk("inst_pc", inst_pc_o, e[63:32]);
                end
            end
        end
    end

    initial begin
        // Reset with ack held high.
        step(0, 1, 32'h0, 0, 0);
        step(0, 1, 32'h0, 0, 0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);

        // Streaming: single-cycle ack, decoder always ready.
        for (int n = 0; n < 12; n++) step(1, 1, 32'hA0 + m_pushes, 1, 0);

        // Fill: decoder stalled, exactly DEPTH pushes, then one pop frees one slot.
        step(1, 1, 32'h0, 1, 1);
        hits = 0;
        for (int n = 0; n < 8; n++) begin
            step(1, 1, 32'h100 + n, 0, 0);
            if (last_inc == 32'd4) hits++;
        end
        chk("full_pushes", hits, DEPTH);
        chk("full_req_off", {31'd0, mem_req_o}, 32'd0);
        step(1, 0, 32'h0, 1, 0);
        hits = 0;
        for (int n = 0; n < 5; n++) begin
            step(1, 1, 32'h200 + n, 0, 0);
            if (last_inc == 32'd4) hits++;
        end
        chk("refill_pushes", hits, 1);

        // Flush while a request is in flight; late data must vanish.
        step(1, 1, 32'h0, 1, 1);
        step(1, 0, 32'h0, 1, 0);
        step(1, 0, 32'h0, 1, 1);
        step(1, 0, 32'h0, 1, 0);
        chk("drop_req", {31'd0, mem_req_o}, 32'd1);
        step(1, 0, 32'h0, 1, 0);
        step(1, 1, 32'hDEAD, 1, 0);
        chk("drop_inc", last_inc, 32'd0);
        chk("drop_valid", {31'd0, inst_valid_o}, 32'd0);

        // Flush coinciding with ack while three entries are queued.
        step(1, 1, 32'h0, 1, 1);
        step(1, 0, 32'h0, 0, 0);
        for (int n = 0; n < 3; n++) step(1, 1, 32'h300 + n, 0, 0);
        step(1, 1, 32'h3FF, 0, 1);
        chk("fack_inc", last_inc, 32'd4);
        chk("fack_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("fack_idle", {31'd0, mem_req_o}, 32'd0);
        step(1, 0, 32'h0, 0, 0);
        chk("fack_req", {31'd0, mem_req_o}, 32'd1);

        // Reset while requesting with two entries queued.
        step(1, 1, 32'h400, 0, 0);
        step(1, 1, 32'h401, 0, 0);
        step(0, 1, 32'h402, 0, 0);
        chk("rmid_req", {31'd0, mem_req_o}, 32'd0);
        chk("rmid_valid", {31'd0, inst_valid_o}, 32'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6), $urandom,
                 ($urandom_range(0, 9) < 5), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port in  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pc_i  input  32  current program counter value (fetch address).
REQ-006 SHALL have port increment_o  output  32  PC step; drives the program counter's increment input.
REQ-007 SHALL have port mem_req_o  output  1  instruction-memory read request.
REQ-008 SHALL have port mem_addr_o  output  32  read address; equals pc_i.
REQ-009 SHALL have port mem_ack_i  input  1  memory accepted request; data valid this cycle.
REQ-010 SHALL have port mem_rdata_i  input  DATA_W  read data, sampled when mem_ack_i=1.
REQ-011 SHALL have port inst_valid_o  output  1  queue head valid.
REQ-012 SHALL have port inst_o  output  DATA_W  queue head instruction.
REQ-013 SHALL have port inst_pc_o  output  32  address the head instruction was fetched from.
REQ-014 SHALL have port inst_ready_i  input  1  decoder consumes head when inst_valid_o=1.
REQ-015 SHALL have port flush_i  input  1  discard queue and any in-flight response.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, DROP.
REQ-017 SHALL assert mem_req_o in REQ and DROP only; mem_addr_o held stable = pc_i until mem_ack_i.
REQ-018 SHALL drive increment_o = 4 combinationally when state is REQ and mem_ack_i=1, else 0 (DROP included).
REQ-019 SHALL transition IDLE->REQ when count<DEPTH and flush_i=0; otherwise stay IDLE.
REQ-020 SHALL, in REQ with mem_ack_i=1 and flush_i=0, push {pc_i, mem_rdata_i}; next state REQ if post-update count<DEPTH, else IDLE (back-to-back: 1 instruction/cycle with single-cycle ack).
REQ-021 SHALL, in REQ with flush_i=1 and mem_ack_i=0, go to DROP; in DROP stay until mem_ack_i=1, discard data, then IDLE.
REQ-022 SHALL, in REQ with flush_i=1 and mem_ack_i=1, discard data, keep increment_o=4, go to IDLE.
REQ-023 SHALL pop head when inst_valid_o=1 and inst_ready_i=1; push+pop same cycle leaves count unchanged.
REQ-024 SHALL drive inst_valid_o = (count!=0); inst_o/inst_pc_o = head entry, stable while not popped.
REQ-025 SHALL on flush_i=1 set count and pointers to 0 next cycle, overriding any same-cycle push or pop.
REQ-026 SHALL never push when full; issue gating of REQ-019/020 guarantees a slot for every accepted response.
REQ-027 SHALL wrap read/write pointers modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-028 SHALL, when in=0 at posedge clk, set state IDLE, count 0, pointers 0; mem_req_o=0, increment_o=0, inst_valid_o=0 from next cycle.
REQ-029 SHALL abandon an outstanding request on reset mid-operation; memory is required to tolerate dropped requests; reset overrides flush_i and all handshakes.
REQ-030 SHALL leave queue data storage unreset.

Structure
REQ-031 SHALL place state enum (IDLE/REQ/DROP) and constant PC_STEP=4 in shared package fetch_pkg.
REQ-032 SHALL instantiate one sub-module sync_fifo (width 32+DATA_W, depth DEPTH, push/pop/flush, count output).

Verification
REQ-033 SHALL check reset: in=0 two cycles with mem_ack_i=1 -> mem_req_o=0, increment_o=0, inst_valid_o=0.
REQ-034 SHALL check streaming: ack every cycle, rdata=0xA0+n, inst_ready_i=1 -> increment_o=4 each cycle, inst_pc_o 0,4,8,... with inst_o 0xA0,0xA1,...
REQ-035 SHALL check full: inst_ready_i=0, ack every cycle -> exactly 4 pushes, then mem_req_o=0, increment_o=0; one pop -> one more request.
REQ-036 SHALL check flush in flight: ack delayed 3 cycles, flush_i pulsed cycle 1 -> state DROP, delayed data 0xDEAD not output, increment_o=0 at ack, inst_valid_o=0.
REQ-037 SHALL check flush with ack same cycle, queue holding 3 -> increment_o=4, next cycle count 0, inst_valid_o=0, state IDLE then REQ.
REQ-038 SHALL check reset mid-REQ with 2 queued -> next cycle IDLE, count 0, mem_req_o=0.
